// File: rtl/flght_seq.sv
// Flight-mode sequencer: spin-up, inertial calibration with timeout, thrust ramp, run.
// All outputs are registered and decoded from the next state.
module flght_seq #(
   parameter int         SPINUP_CYCLES = 16,
   parameter int         CAL_TIMEOUT   = 64,
   parameter logic [8:0] RAMP_STEP     = 9'h010,
   parameter int         CNT_W         = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       go_cal,
   input  logic       cal_done,
   input  logic       stop,
   input  logic       vld,
   input  logic [8:0] thrst_cmd,
   output logic       inertial_cal,
   output logic       motors_off,
   output logic [8:0] thrst,
   output logic       cal_err,
   output logic       busy
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_SPINUP = 3'd1,
      S_CAL    = 3'd2,
      S_RAMP   = 3'd3,
      S_RUN    = 3'd4
   } state_t;

   localparam logic [CNT_W-1:0] SPIN_LAST = CNT_W'(SPINUP_CYCLES - 1);
   localparam logic [CNT_W-1:0] CAL_LAST  = CNT_W'(CAL_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] cnt_inc;
   logic [8:0]       thrst_q, thrst_d;
   logic             cal_err_q, cal_err_d;
   logic             motors_off_q, motors_off_d;
   logic             inertial_cal_q, inertial_cal_d;
   logic             busy_q, busy_d;
   logic [9:0]       ramp_sum;

   // State register and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= S_IDLE;
         cnt_q          <= '0;
         thrst_q        <= '0;
         cal_err_q      <= 1'b0;
         motors_off_q   <= 1'b1;
         inertial_cal_q <= 1'b0;
         busy_q         <= 1'b0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         thrst_q        <= thrst_d;
         cal_err_q      <= cal_err_d;
         motors_off_q   <= motors_off_d;
         inertial_cal_q <= inertial_cal_d;
         busy_q         <= busy_d;
      end
   end

   // Saturating increment keeps the shared counter from wrapping
   assign cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + CNT_ONE;
   assign ramp_sum = {1'b0, thrst_q} + {1'b0, RAMP_STEP};

   // Next-state and thrust datapath
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      thrst_d   = thrst_q;
      cal_err_d = cal_err_q;
      if (stop) begin
         state_d = S_IDLE;
         thrst_d = '0;
         cnt_d   = '0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               thrst_d = '0;
               if (go_cal) begin
                  state_d   = S_SPINUP;
                  cnt_d     = '0;
                  cal_err_d = 1'b0;
               end
            end
            S_SPINUP: begin
               if (cnt_q == SPIN_LAST) begin
                  state_d = S_CAL;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_inc;
               end
            end
            S_CAL: begin
               // cal_done beats a simultaneous timeout
               if (cal_done) begin
                  state_d = S_RAMP;
                  cnt_d   = '0;
               end else if (cnt_q == CAL_LAST) begin
                  state_d   = S_IDLE;
                  cal_err_d = 1'b1;
                  cnt_d     = '0;
               end else begin
                  cnt_d = cnt_inc;
               end
            end
            S_RAMP: begin
               if (vld) begin
                  if (ramp_sum >= {1'b0, thrst_cmd}) begin
                     thrst_d = thrst_cmd;
                     state_d = S_RUN;
                  end else begin
                     thrst_d = ramp_sum[8:0];
                  end
               end
            end
            S_RUN: begin
               if (vld) thrst_d = thrst_cmd;
            end
            default: begin
               state_d = S_IDLE;
               thrst_d = '0;
               cnt_d   = '0;
            end
         endcase
      end
   end

   // Output decode from the next state
   always_comb begin
      motors_off_d   = (state_d == S_IDLE);
      inertial_cal_d = (state_d == S_SPINUP) || (state_d == S_CAL);
      busy_d         = (state_d != S_IDLE);
   end

   assign inertial_cal = inertial_cal_q;
   assign motors_off   = motors_off_q;
   assign thrst        = thrst_q;
   assign cal_err      = cal_err_q;
   assign busy         = busy_q;

endmodule

// File: tb/tb_flght_seq.sv
// Bench for flght_seq: directed scenarios plus randomized traffic against a
// behavioural model built from countdowns and plain integer thrust arithmetic.
module tb_flght_seq;

   localparam int SPIN = 16;
   localparam int CALT = 64;
   localparam int STEP = 16;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       go_cal = 1'b0, cal_done = 1'b0, stop = 1'b0, vld = 1'b0;
   logic [8:0] thrst_cmd = 9'h0;
   logic       inertial_cal, motors_off, cal_err, busy;
   logic [8:0] thrst;
   logic [12:0] dut_o;

   int checks = 0;
   int errs   = 0;

   flght_seq dut (
      .clk(clk), .rst(rst), .go_cal(go_cal), .cal_done(cal_done), .stop(stop),
      .vld(vld), .thrst_cmd(thrst_cmd), .inertial_cal(inertial_cal),
      .motors_off(motors_off), .thrst(thrst), .cal_err(cal_err), .busy(busy)
   );

   always #5 clk = ~clk;
   assign dut_o = {motors_off, inertial_cal, busy, cal_err, thrst};

   // Model: mode 0 idle, 1 spinning, 2 calibrating, 3 ramping, 4 running
   int m_mode, m_spin_left, m_cal_age, m_thr;
   bit m_err;

   task automatic model_reset();
      m_mode = 0; m_spin_left = 0; m_cal_age = 0; m_thr = 0; m_err = 0;
   endtask

   task automatic model_step();
      int s;
      if (rst) begin
         model_reset();
      end else if (stop) begin
         m_mode = 0; m_thr = 0;
      end else begin
         case (m_mode)
            0: if (go_cal) begin m_mode = 1; m_spin_left = SPIN; m_err = 0; end
            1: begin
               m_spin_left--;
               if (m_spin_left == 0) begin m_mode = 2; m_cal_age = 0; end
            end
            2: begin
               if (cal_done) m_mode = 3;
               else if (m_cal_age == CALT - 1) begin m_mode = 0; m_err = 1; end
               else m_cal_age++;
            end
            3: if (vld) begin
               s = m_thr + STEP;
               if (s >= int'(thrst_cmd)) begin m_thr = int'(thrst_cmd); m_mode = 4; end
               else m_thr = s;
            end
            default: if (vld) m_thr = int'(thrst_cmd);
         endcase
      end
   endtask

   function automatic logic [12:0] exp_o();
      return {m_mode == 0, (m_mode == 1) || (m_mode == 2), m_mode != 0, m_err, 9'(m_thr)};
   endfunction

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic to_ramp(input int cal_delay);
      go_cal = 1; tick(); go_cal = 0;
      repeat (SPIN + cal_delay) tick();
      cal_done = 1; tick(); cal_done = 0;
   endtask

   task automatic to_idle();
      stop = 1; tick(); stop = 0;
   endtask

   task automatic test_reset();
      rst = 1;
      repeat (2) tick();
      rst = 0;
      #1;
      checks++; if (motors_off !== 1'b1) begin errs++; $display("FAIL reset_motors_off got=%b want=1", motors_off); end
      checks++; if (inertial_cal !== 1'b0) begin errs++; $display("FAIL reset_inertial_cal got=%b want=0", inertial_cal); end
      checks++; if (thrst !== 9'h0) begin errs++; $display("FAIL reset_thrst got=%h want=000", thrst); end
      checks++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy got=%b want=0", busy); end
      checks++; if (cal_err !== 1'b0) begin errs++; $display("FAIL reset_cal_err got=%b want=0", cal_err); end
      cal_done = 1; tick(); cal_done = 0; tick();
      checks++; if (dut_o !== 13'h1000) begin errs++; $display("FAIL idle_cal_done got=%h want=1000", dut_o); end
      $display("scenario reset: checks=%0d errors=%0d", checks, errs);
   endtask

   task automatic test_nominal();
      logic [8:0] exp9;
      go_cal = 1; tick(); go_cal = 0;
      checks++; if (inertial_cal !== 1'b1 || motors_off !== 1'b0) begin
         errs++; $display("FAIL spinup_entry got cal=%b off=%b want cal=1 off=0", inertial_cal, motors_off); end
      for (int i = 0; i < SPIN - 1; i++) begin
         tick();
         checks++; if (dut_o !== exp_o()) begin errs++; $display("FAIL spinup_cyc%0d got=%h want=%h", i, dut_o, exp_o()); end
      end
      cal_done = 1; tick(); cal_done = 0;
      checks++; if (inertial_cal !== 1'b1 || dut_o !== exp_o()) begin
         errs++; $display("FAIL spinup_ignores_cal_done got=%h want=%h", dut_o, exp_o()); end
      repeat (4) tick();
      cal_done = 1; tick(); cal_done = 0;
      checks++; if (inertial_cal !== 1'b0 || busy !== 1'b1) begin
         errs++; $display("FAIL cal_done_cyc5 got cal=%b busy=%b want cal=0 busy=1", inertial_cal, busy); end
      thrst_cmd = 9'h123; vld = 1;
      for (int i = 1; i <= 19; i++) begin
         tick();
         exp9 = (i < 19) ? 9'(i * STEP) : 9'h123;
         checks++; if (thrst !== exp9) begin errs++; $display("FAIL ramp_vld%0d got=%h want=%h", i, thrst, exp9); end
      end
      thrst_cmd = 9'h0A0; tick();
      checks++; if (thrst !== 9'h0A0) begin errs++; $display("FAIL run_follow got=%h want=0a0", thrst); end
      vld = 0;
      to_idle();
      $display("scenario nominal: checks=%0d errors=%0d", checks, errs);
   endtask

   task automatic test_timeout();
      go_cal = 1; tick(); go_cal = 0;
      for (int i = 0; i < SPIN + CALT; i++) begin
         tick();
         checks++; if (dut_o !== exp_o()) begin errs++; $display("FAIL timeout_cyc%0d got=%h want=%h", i, dut_o, exp_o()); end
      end
      checks++; if (busy !== 1'b0 || cal_err !== 1'b1 || motors_off !== 1'b1) begin
         errs++; $display("FAIL timeout_end got busy=%b err=%b off=%b want 0 1 1", busy, cal_err, motors_off); end
      go_cal = 1; tick(); go_cal = 0;
      checks++; if (cal_err !== 1'b0 || busy !== 1'b1) begin
         errs++; $display("FAIL go_cal_clears_err got err=%b busy=%b want 0 1", cal_err, busy); end
      repeat (SPIN + CALT - 1) tick();
      cal_done = 1; tick(); cal_done = 0;
      checks++; if (inertial_cal !== 1'b0 || busy !== 1'b1 || cal_err !== 1'b0) begin
         errs++; $display("FAIL cal_done_at_timeout got cal=%b busy=%b err=%b want 0 1 0", inertial_cal, busy, cal_err); end
      to_idle();
      $display("scenario timeout: checks=%0d errors=%0d", checks, errs);
   endtask

   task automatic test_vld_gating();
      thrst_cmd = 9'h100;
      to_ramp(1);
      vld = 1; repeat (4) tick();
      checks++; if (thrst !== 9'h040) begin errs++; $display("FAIL ramp_to_040 got=%h want=040", thrst); end
      vld = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++; if (thrst !== 9'h040 || dut_o !== exp_o()) begin errs++; $display("FAIL vld_hold%0d got=%h want=040", i, thrst); end
      end
      vld = 1; tick();
      checks++; if (thrst !== 9'h050) begin errs++; $display("FAIL ramp_resume got=%h want=050", thrst); end
      thrst_cmd = 9'h030; tick();
      checks++; if (thrst !== 9'h030) begin errs++; $display("FAIL ramp_cmd_lowered got=%h want=030", thrst); end
      thrst_cmd = 9'h1FF; tick();
      checks++; if (thrst !== 9'h1FF) begin errs++; $display("FAIL run_after_lower got=%h want=1ff", thrst); end
      vld = 0;
      to_idle();
      $display("scenario vld_gating: checks=%0d errors=%0d", checks, errs);
   endtask

   task automatic test_stop();
      go_cal = 1; tick(); go_cal = 0;
      repeat (SPIN + 2) tick();
      stop = 1; cal_done = 1; tick(); stop = 0; cal_done = 0;
      checks++; if (dut_o !== 13'h1000) begin errs++; $display("FAIL stop_vs_cal_done got=%h want=1000", dut_o); end
      tick();
      checks++; if (dut_o !== 13'h1000) begin errs++; $display("FAIL stop_stays_idle got=%h want=1000", dut_o); end
      thrst_cmd = 9'h123;
      to_ramp(0);
      vld = 1; repeat (19) tick();
      checks++; if (thrst !== 9'h123) begin errs++; $display("FAIL run_at_123 got=%h want=123", thrst); end
      thrst_cmd = 9'h055; stop = 1; tick(); stop = 0; vld = 0;
      checks++; if (dut_o !== 13'h1000) begin errs++; $display("FAIL stop_vs_vld got=%h want=1000", dut_o); end
      $display("scenario stop: checks=%0d errors=%0d", checks, errs);
   endtask

   task automatic test_async_reset();
      thrst_cmd = 9'h1FF;
      to_ramp(2);
      vld = 1; repeat (3) tick(); vld = 0;
      @(negedge clk);
      rst = 1; #1;
      model_reset();
      checks++; if (dut_o !== 13'h1000) begin errs++; $display("FAIL async_reset got=%h want=1000", dut_o); end
      go_cal = 1;
      @(posedge clk); #1;
      rst = 0; go_cal = 0;
      for (int i = 0; i < 2; i++) begin
         tick();
         checks++; if (dut_o !== 13'h1000) begin errs++; $display("FAIL go_cal_at_release%0d got=%h want=1000", i, dut_o); end
      end
      $display("scenario async_reset: checks=%0d errors=%0d", checks, errs);
   endtask

   task automatic test_random();
      int sel;
      for (int i = 0; i < 3000; i++) begin
         stop     = ($urandom_range(63) == 0);
         go_cal   = ($urandom_range(15) == 0);
         cal_done = ($urandom_range(7) == 0);
         vld      = ($urandom_range(1) == 0);
         sel = int'($urandom_range(7));
         thrst_cmd = (sel == 0) ? 9'h000 : (sel == 1) ? 9'h1FF : 9'($urandom);
         tick();
         checks++; if (dut_o !== exp_o()) begin errs++; $display("FAIL random_cyc%0d got=%h want=%h", i, dut_o, exp_o()); end
      end
      stop = 0; go_cal = 0; cal_done = 0; vld = 0;
      $display("scenario random: checks=%0d errors=%0d", checks, errs);
   endtask

   initial begin
      model_reset();
      test_reset();
      test_nominal();
      test_timeout();
      test_vld_gating();
      test_stop();
      test_async_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
